// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Owns the register file write port. Single-cycle ALU results and buffered
// long-latency results (load/mul/div) compete for one registered write per
// cycle. Long-latency results enter an in-order FIFO over valid/ready.
// Writes to x0 are dropped. If buffered results are bypassed by the ALU for
// STARVE_LIMIT consecutive cycles, alu_stall holds the ALU off for one cycle
// so that the FIFO head can drain.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data   ALU write request (no backpressure)
//   ll_valid/ll_ready/ll_rd/ll_data  long-latency result handshake
//   AD3/WE3/WD3              registered register-file write port
//   alu_stall                registered stall toward the pipeline
//   fifo_count               occupied FIFO entries
module writeback_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          ll_valid,
  output logic                          ll_ready,
  input  logic [ADDRESS_WIDTH-1:0]      ll_rd,
  input  logic [DATA_WIDTH-1:0]         ll_data,
  output logic [ADDRESS_WIDTH-1:0]      AD3,
  output logic                          WE3,
  output logic [DATA_WIDTH-1:0]         WD3,
  output logic                          alu_stall,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDRESS_WIDTH-1:0] rd_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [STV_W-1:0]         starve_q, starve_d;
  logic                     stall_q, stall_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;

  logic fifo_empty, fifo_full, alu_req, push, pop, alu_win;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    ll_ready   = rst_n && !fifo_full;
    alu_req    = alu_valid && (alu_rd != '0);
    // rd=0 results complete the handshake but are never stored.
    push       = ll_valid && ll_ready && (ll_rd != '0);
    // A stalled cycle always drains the head, dropping any ALU request.
    pop        = !fifo_empty && (stall_q || !alu_req);
    alu_win    = alu_req && !pop;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_win && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
    stall_d = (starve_d == STV_W'(STARVE_LIMIT));

    we_d = pop || alu_win;
    ad_d = ad_q;
    wd_d = wd_q;
    if (pop) begin
      ad_d = rd_mem_q[rd_ptr_q];
      wd_d = data_mem_q[rd_ptr_q];
    end else if (alu_win) begin
      ad_d = alu_rd;
      wd_d = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      ad_q     <= '0;
      wd_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      ad_q     <= ad_d;
      wd_q     <= wd_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= ll_rd;
      data_mem_q[wr_ptr_q] <= ll_data;
    end
  end

  assign AD3        = ad_q;
  assign WE3        = we_q;
  assign WD3        = wd_q;
  assign alu_stall  = stall_q;
  assign fifo_count = count_q;

endmodule
